lru_victim_scan: RTL and testbench
==================================

# lru_victim_scan

Sequential LRU victim selector for the fully associative cache. Keeps a saturating age counter per way, updates ages on every cache touch, and on request scans the ways one per cycle with a running max-age comparison to pick the replacement victim. Sits between the cache controller's miss path and the tag/data arrays: the controller requests a victim, waits for the result handshake, then fills that way.

## Interface
- NUM_WAYS, 8, number of cache ways (≥2, power of two)
- AGE_WIDTH, 4, bits per age counter; ages saturate at 2^AGE_WIDTH-1
- INDEX_WIDTH, $clog2(NUM_WAYS), way index width (derived, not overridden)

- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  asynchronous active-low reset
- touch_v_i  input  1  a way was accessed (hit or fill) this cycle
- touch_way_i  input  INDEX_WIDTH  way accessed
- valid_i  input  NUM_WAYS  per-way valid bits from the tag array
- req_v_i  input  1  victim request
- req_ready_o  output  1  high in IDLE only; request accepted when req_v_i & req_ready_o
- victim_v_o  output  1  result valid
- victim_way_o  output  INDEX_WIDTH  selected way
- victim_age_o  output  AGE_WIDTH  age of selected way at the time it was examined
- victim_ready_i  input  1  consumer accepts result
- busy_o  output  1  high in SCAN or DONE

## Operation
- Ages: touch_v_i sets age[touch_way_i] to 0; every other way increments by 1, saturating at max. No touch → ages hold.
- FSM states IDLE, SCAN, DONE.
- IDLE: req_ready_o=1. Accepted request → SCAN, scan index k=0, best cleared.
- SCAN: examines way k per cycle using the live age in that cycle. k=0 loads best={0, age[0]}. For k>0, candidate replaces best only if age[k] > best age (strict; ties keep lowest index). After k=NUM_WAYS-1 → DONE.
- DONE: victim_v_o=1, outputs stable while held. victim_v_o & victim_ready_i → IDLE.
- Touches are legal in every state and update ages in the same cycle; a way already passed by the scan is not re-examined.
- req_v_i outside IDLE is ignored (not queued).
- Age arithmetic is unsigned, AGE_WIDTH bits; the increment never wraps.

## Timing
- Reset: all ages 0, state IDLE, req_ready_o=1, victim_v_o=0, victim_way_o=0, victim_age_o=0, busy_o=0.
- Request accepted at edge T: way k examined in cycle T+1+k; victim_v_o rises at edge T+NUM_WAYS+1 (full-scan latency NUM_WAYS+1 cycles).
- Same-cycle handshake and new request: impossible; req_ready_o is low in DONE, so a new request is accepted no earlier than the cycle after the handshake.
- Touch in the same cycle as an examination: the comparison uses the pre-update age (register value).
- Reset asserted mid-scan or in DONE: immediately returns to IDLE and clears all state; no result is produced.
- All ages saturated and equal: victim is way 0.

## Configuration
- LRU_INVALID_FIRST_EN defined: during SCAN, if valid_i[k]==0, that way becomes the victim immediately, the scan terminates, and the FSM enters DONE next edge. Latency is k+2 cycles from acceptance. victim_age_o reports that way's age.
- Undefined: valid_i is ignored; the scan always covers all ways and selects purely by maximum age.

## Test plan
- Reset then request, no touches, NUM_WAYS=8 → victim_v_o at cycle 9 after acceptance, way 0, age 0; req_ready_o low throughout.
- Touch ways 0..7 in order, then request → ages 7,6,…,0; victim way 0, age 7.
- Touch way 3 twenty times with AGE_WIDTH=4 → other ways saturate at 15, no wrap; request → victim way 0 (tie, lowest index), age 15.
- Hold victim_ready_i low 5 cycles in DONE while touching way 2 → outputs stable; req_v_i ignored; handshake → IDLE next cycle.
- Assert rst_n_i low during scan cycle 4 → outputs return to reset values asynchronously; no victim_v_o pulse.
- With LRU_INVALID_FIRST_EN and valid_i=8'b1110_1111 (way 4 invalid) → victim way 4 at cycle 6 after acceptance; without the macro → full-scan max-age result.

Source files
------------

// File: rtl/lru_victim_scan.sv
// lru_victim_scan: saturating per-way LRU ages plus a one-way-per-cycle max-age victim scan.
// Optional LRU_INVALID_FIRST_EN: the first invalid way reached by the scan wins at once.
module lru_victim_scan #(
    parameter int NUM_WAYS = 8,
    parameter int AGE_WIDTH = 4,
    localparam int INDEX_WIDTH = $clog2(NUM_WAYS)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   touch_v_i,
    input  logic [INDEX_WIDTH-1:0] touch_way_i,
    input  logic [NUM_WAYS-1:0]    valid_i,
    input  logic                   req_v_i,
    output logic                   req_ready_o,
    output logic                   victim_v_o,
    output logic [INDEX_WIDTH-1:0] victim_way_o,
    output logic [AGE_WIDTH-1:0]   victim_age_o,
    input  logic                   victim_ready_i,
    output logic                   busy_o
);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t                 state;
    logic [AGE_WIDTH-1:0]   age [NUM_WAYS];
    logic [INDEX_WIDTH-1:0] k;
    logic                   primed;
    logic                   hole;
    logic                   take;
    logic                   last;
`ifdef LRU_INVALID_FIRST_EN
    assign hole = !valid_i[k];
`else
    logic unused_valid;
    assign hole = 1'b0;
    assign unused_valid = ^valid_i;
`endif
    // ties keep the earlier (lower) way because the comparison is strict
    assign take = (k == '0) || (age[k] > victim_age_o) || hole;
    assign last = (k == INDEX_WIDTH'(NUM_WAYS - 1)) || hole;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_WAYS; i++) age[i] <= '0;
        end else if (touch_v_i) begin
            for (int i = 0; i < NUM_WAYS; i++)
                age[i] <= (touch_way_i == INDEX_WIDTH'(i)) ? '0 :
                          (age[i] == AGE_MAX) ? AGE_MAX : age[i] + 1'b1;
        end
    end
    // the first SCAN cycle only primes the scan; way k is examined in the cycle after
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            k            <= '0;
            primed       <= 1'b0;
            victim_way_o <= '0;
            victim_age_o <= '0;
            req_ready_o  <= 1'b1;
            victim_v_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_v_i) begin
                    state        <= SCAN;
                    k            <= '0;
                    primed       <= 1'b0;
                    victim_way_o <= '0;
                    victim_age_o <= '0;
                    req_ready_o  <= 1'b0;
                    busy_o       <= 1'b1;
                end
                SCAN: if (!primed) begin
                    primed <= 1'b1;
                end else begin
                    if (take) begin
                        victim_way_o <= k;
                        victim_age_o <= age[k];
                    end
                    if (last) begin
                        state      <= DONE;
                        victim_v_o <= 1'b1;
                    end
                    k <= k + 1'b1;
                end
                DONE: if (victim_ready_i) begin
                    state       <= IDLE;
                    victim_v_o  <= 1'b0;
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lru_victim_scan.sv
// tb_lru_victim_scan: directed stimulus with a behavioural age/victim model checked every cycle.
module tb_lru_victim_scan;
    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       touch_v_i = 1'b0;
    logic [2:0] touch_way_i = '0;
    logic [7:0] valid_i = 8'hff;
    logic       req_v_i = 1'b0;
    logic       req_ready_o;
    logic       victim_v_o;
    logic [2:0] victim_way_o;
    logic [3:0] victim_age_o;
    logic       victim_ready_i = 1'b0;
    logic       busy_o;
    int total = 0;
    int bad = 0;

    lru_victim_scan #(.NUM_WAYS(8), .AGE_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .touch_v_i(touch_v_i), .touch_way_i(touch_way_i),
        .valid_i(valid_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o), .victim_v_o(victim_v_o),
        .victim_way_o(victim_way_o), .victim_age_o(victim_age_o), .victim_ready_i(victim_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: ages as integers; a request accepted at edge T examines way k with the
    // ages that hold during the period after edge T+1+k.
    int m_age [8];
    int m_busy, m_done, m_since, m_way, m_agev;
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            foreach (m_age[i]) m_age[i] = 0;
            m_busy = 0; m_done = 0; m_since = 0; m_way = 0; m_agev = 0;
        end else begin
            if (m_done && victim_ready_i) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy && req_v_i) begin
                m_busy = 1; m_since = 0; m_way = 0; m_agev = 0;
            end else if (m_busy && !m_done) begin
                if (m_since >= 1) begin
                    int kk;
                    kk = m_since - 1;
                    if (kk == 0 || m_age[kk] > m_agev) begin m_way = kk; m_agev = m_age[kk]; end
`ifdef LRU_INVALID_FIRST_EN
                    if (!valid_i[kk]) begin m_way = kk; m_agev = m_age[kk]; m_done = 1; end
`endif
                    if (kk == 7) m_done = 1;
                end
                m_since++;
            end
            if (touch_v_i)
                foreach (m_age[i]) m_age[i] = (i == int'(touch_way_i)) ? 0 : (m_age[i] < 15 ? m_age[i] + 1 : 15);
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            check("ready", int'(req_ready_o), m_busy ? 0 : 1);
            check("busy", int'(busy_o), m_busy);
            check("valid", int'(victim_v_o), m_done);
            if (m_done) begin
                check("way", int'(victim_way_o), m_way);
                check("age", int'(victim_age_o), m_agev);
            end
        end
    end

    task automatic request(output int lat);
        @(negedge clk_i) req_v_i = 1'b1;
        @(negedge clk_i) req_v_i = 1'b0;
        lat = 0;
        while (!victim_v_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        if (!victim_v_o) check("timeout", 0, 1);
    endtask

    task automatic handshake();
        @(negedge clk_i) victim_ready_i = 1'b1;
        @(negedge clk_i) victim_ready_i = 1'b0;
        check("hs_ready", int'(req_ready_o), 1);
        check("hs_valid", int'(victim_v_o), 0);
    endtask

    task automatic touch_seq(input int way, input int n);
        repeat (n) begin
            @(negedge clk_i);
            touch_v_i = 1'b1;
            touch_way_i = 3'(way);
        end
        @(negedge clk_i) touch_v_i = 1'b0;
    endtask

    initial begin
        int lat, seen;
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen;
        repeat (2) @(negedge clk_i);
        check("rst_ready", int'(req_ready_o), 1);
        check("rst_valid", int'(victim_v_o), 0);
        check("rst_way", int'(victim_way_o), 0);
        check("rst_age", int'(victim_age_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_n_i = 1'b1;
        // no touches: all ages 0
        request(lat);
        check("lat_full", lat, 9);
        check("idle_way", int'(victim_way_o), 0);
        check("idle_age", int'(victim_age_o), 0);
        handshake();
        // touches 0..7 leave ages 7..0
        for (int i = 0; i < 8; i++) touch_seq(i, 1);
        request(lat);
        check("seq_way", int'(victim_way_o), 0);
        check("seq_age", int'(victim_age_o), 7);
        handshake();
        // saturation: others stick at 15, tie resolves to way 0
        touch_seq(3, 20);
        request(lat);
        check("sat_way", int'(victim_way_o), 0);
        check("sat_age", int'(victim_age_o), 15);
        handshake();
        // DONE held with touches and ignored requests
        request(lat);
        for (int i = 0; i < 5; i++) begin
            touch_v_i = 1'b1; touch_way_i = 3'd2; req_v_i = 1'b1;
            @(negedge clk_i);
            check("hold_valid", int'(victim_v_o), 1);
            check("hold_way", int'(victim_way_o), 0);
            check("hold_age", int'(victim_age_o), 15);
            check("hold_ready", int'(req_ready_o), 0);
        end
        touch_v_i = 1'b0; req_v_i = 1'b0;
        handshake();
        // asynchronous reset during the scan
        @(negedge clk_i) req_v_i = 1'b1;
        @(negedge clk_i) req_v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_ready", int'(req_ready_o), 1);
        check("arst_valid", int'(victim_v_o), 0);
        check("arst_way", int'(victim_way_o), 0);
        check("arst_age", int'(victim_age_o), 0);
        check("arst_busy", int'(busy_o), 0);
        @(negedge clk_i) rst_n_i = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            seen += int'(victim_v_o);
        end
        check("arst_no_pulse", seen, 0);
        // way 4 invalid with ages 7..0
        for (int i = 0; i < 8; i++) touch_seq(i, 1);
        valid_i = 8'b1110_1111;
        request(lat);
`ifdef LRU_INVALID_FIRST_EN
        check("inv_lat", lat, 6);
        check("inv_way", int'(victim_way_o), 4);
        check("inv_age", int'(victim_age_o), 3);
`else
        check("inv_lat", lat, 9);
        check("inv_way", int'(victim_way_o), 0);
        check("inv_age", int'(victim_age_o), 7);
`endif
        handshake();
        valid_i = 8'hff;
        // touches landing during the scan, checked by the model
        for (int r = 0; r < 4; r++) begin
            @(negedge clk_i) req_v_i = 1'b1;
            @(negedge clk_i) req_v_i = 1'b0;
            lat = 0;
            while (!victim_v_o && lat < 40) begin
                touch_v_i = 1'($urandom_range(0, 1));
                touch_way_i = 3'($urandom_range(0, 7));
                @(negedge clk_i);
                lat++;
            end
            touch_v_i = 1'b0;
            check("rand_lat", lat, 9);
            handshake();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
